// File: rtl/pwm_capture_if.sv
// pwm_capture_if: measurement bus of the PWM capture block.
//   pwm_in  - asynchronous PWM waveform under measurement
//   dvsr    - tick prescale, one tick every dvsr+1 clocks
//   duty    - measured high time in ticks (0..2^R)
//   period  - measured period in ticks (0 after a timeout)
//   valid   - one-clock pulse when duty/period update
//   timeout - high while no rising edge arrived within 2^(R+1) ticks
// R must match the R of the pwm_capture instance it connects to.
interface pwm_capture_if #(
  parameter int unsigned R = 8
);
  logic          pwm_in;
  logic [31:0]   dvsr;
  logic [R:0]    duty;
  logic [R+1:0]  period;
  logic          valid;
  logic          timeout;

  modport master (
    output pwm_in, dvsr,
    input  duty, period, valid, timeout
  );

  modport slave (
    input  pwm_in, dvsr,
    output duty, period, valid, timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input
// in prescaled ticks, with timeout detection when rising edges stop.
// Ports:
//   clk  - system clock, all state on its rising edge
//   rst  - asynchronous active-high reset
//   bus  - pwm_capture_if.slave (pwm_in, dvsr in; duty, period, valid,
//          timeout out, all outputs registered)
// Optional feature: define PWM_CAP_GLITCH_FILTER_EN to add a 3-clock
// persistence filter after the synchronizer (+2 clocks latency).
module pwm_capture #(
  parameter int unsigned R = 8
) (
  input  logic         clk,
  input  logic         rst,
  pwm_capture_if.slave bus
);

  localparam int unsigned CW = R + 2;
  localparam int unsigned DW = R + 1;
  localparam logic [CW-1:0] FULL_SCALE = CW'(1) << R;
  localparam logic [CW-1:0] TO_LIMIT   = CW'(1) << (R + 1);
  localparam logic [CW-1:0] PER_MAX    = TO_LIMIT - CW'(1);

  typedef enum logic {WAIT, RUN} state_t;

  logic          sync_meta;
  logic          sync_out;
  logic          s;
  logic          s_q;
  logic          rise;
  logic          fall;
  logic          tick;
  logic [31:0]   presc;
  logic [31:0]   dvsr_q;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;
  state_t        state;
  logic          timed_out;
  logic [DW-1:0] duty_q;
  logic [CW-1:0] period_q;
  logic          valid_q;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= bus.pwm_in;
      sync_out  <= sync_meta;
    end
  end

`ifdef PWM_CAP_GLITCH_FILTER_EN
  logic filt_d1;
  logic filt_d2;

  // s follows the synchronized input only once three consecutive samples
  // agree; s is combinational so the added latency is two clocks, not three.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_d1 <= 1'b0;
      filt_d2 <= 1'b0;
    end else begin
      filt_d1 <= sync_out;
      filt_d2 <= filt_d1;
    end
  end

  assign s = ((sync_out == filt_d1) && (filt_d1 == filt_d2)) ? sync_out : s_q;
`else
  assign s = sync_out;
`endif

  // Previous value of s: filter hold value and edge-detect reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0;
    end else begin
      s_q <= s;
    end
  end

  assign rise = s & ~s_q;
  assign fall = ~s & s_q;
  assign tick = (presc == dvsr_q);

  // Prescaler; dvsr is sampled only when the count restarts so a new value
  // never lands in the middle of a tick interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      dvsr_q <= '0;
    end else if (rise || tick) begin
      presc  <= '0;
      dvsr_q <= bus.dvsr;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  // Tick counters. The rising edge restarts the prescaler, so the edge cycle
  // is itself the first tick of the new period (and it is a high tick).
  // Counting stops at the timeout limit until the next rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CW'(1);
      high_cnt   <= CW'(1);
    end else if (tick && !timed_out && (period_cnt != TO_LIMIT)) begin
      period_cnt <= period_cnt + CW'(1);
      if (s) begin
        high_cnt <= high_cnt + CW'(1);
      end
    end
  end

  // Measurement FSM with registered results; a rising edge outranks a
  // timeout detected in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT;
      timed_out <= 1'b0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rise) begin
        timed_out <= 1'b0;
        state     <= RUN;
        if (state == RUN) begin
          // A period equal to the timeout window reads one below it.
          period_q <= (period_cnt > PER_MAX) ? PER_MAX : period_cnt;
          duty_q   <= (high_cnt > FULL_SCALE) ? DW'(FULL_SCALE) : DW'(high_cnt);
          valid_q  <= 1'b1;
        end
      end else if (timed_out) begin
        // Only a fall can occur here; report the new static level.
        if (fall) begin
          duty_q  <= '0;
          valid_q <= 1'b1;
        end
      end else if (period_cnt == TO_LIMIT) begin
        timed_out <= 1'b1;
        state     <= WAIT;
        period_q  <= '0;
        duty_q    <= s ? DW'(FULL_SCALE) : '0;
        valid_q   <= 1'b1;
      end
    end
  end

  assign bus.duty    = duty_q;
  assign bus.period  = period_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timed_out;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed, table-driven bench for pwm_capture (R=8).
module tb_pwm_capture;

  localparam int unsigned R = 8;

  typedef struct {
    int dvsr;
    int high;
    int low;
    int exp_duty;
    int exp_period;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  pwm_capture_if #(.R(R)) bus ();

  pwm_capture #(.R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int valid_cnt;
  int to_cnt;
  int cap_duty;
  int cap_period;

  // Observes outputs away from the active edge.
  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt  <= valid_cnt + 1;
      cap_duty   <= int'(bus.duty);
      cap_period <= int'(bus.period);
    end
    if (bus.timeout) begin
      to_cnt <= to_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Holds pwm_in at a level for n clocks; starts and ends 1 time unit after a rising edge.
  task automatic drive(input logic level, input int n);
    bus.pwm_in = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int d);
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    bus.dvsr   = 32'(d);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[6];
  int   vbase;
  int   tbase;

  initial begin
    vecs[0] = '{dvsr: 4, high: 320, low: 960, exp_duty: 64,  exp_period: 256};
    vecs[1] = '{dvsr: 0, high: 10,  low: 30,  exp_duty: 10,  exp_period: 40};
    vecs[2] = '{dvsr: 1, high: 100, low: 100, exp_duty: 50,  exp_period: 100};
    vecs[3] = '{dvsr: 0, high: 300, low: 100, exp_duty: 256, exp_period: 400};
    vecs[4] = '{dvsr: 2, high: 3,   low: 297, exp_duty: 1,   exp_period: 100};
    vecs[5] = '{dvsr: 0, high: 3,   low: 508, exp_duty: 3,   exp_period: 511};

    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    bus.pwm_in = 1'b0;
    bus.dvsr   = 32'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_duty",    int'(bus.duty),    0);
    check("rst_period",  int'(bus.period),  0);
    check("rst_valid",   int'(bus.valid),   0);
    check("rst_timeout", int'(bus.timeout), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Steady-state measurements: first edge arms, next two each report.
    for (int i = 0; i < 6; i++) begin
      apply_reset(vecs[i].dvsr);
      drive(1'b0, 5);
      vbase = valid_cnt;
      tbase = to_cnt;
      drive(1'b1, vecs[i].high);
      drive(1'b0, vecs[i].low);
      drive(1'b1, vecs[i].high);
      drive(1'b0, vecs[i].low);
      drive(1'b1, 3);
      drive(1'b0, 10);
      check($sformatf("vec%0d_valid_cnt", i), valid_cnt - vbase, 2);
      check($sformatf("vec%0d_duty", i),      cap_duty,   vecs[i].exp_duty);
      check($sformatf("vec%0d_period", i),    cap_period, vecs[i].exp_period);
      check($sformatf("vec%0d_no_timeout", i), to_cnt - tbase, 0);
    end

    // Input held low after one rising edge: timeout reporting duty 0.
    apply_reset(0);
    drive(1'b0, 5);
    vbase = valid_cnt;
    drive(1'b1, 5);
    drive(1'b0, 530);
    check("lo_to_timeout", int'(bus.timeout), 1);
    check("lo_to_duty",    int'(bus.duty),    0);
    check("lo_to_period",  int'(bus.period),  0);
    check("lo_to_valid_cnt", valid_cnt - vbase, 1);
    drive(1'b0, 100);
    check("lo_to_no_repulse", valid_cnt - vbase, 1);
    check("lo_to_still_set",  int'(bus.timeout), 1);

    // Input held high: timeout with full-scale duty, fall reports, rise clears.
    apply_reset(0);
    drive(1'b0, 5);
    vbase = valid_cnt;
    drive(1'b1, 530);
    check("hi_to_timeout",   int'(bus.timeout), 1);
    check("hi_to_duty",      int'(bus.duty),    256);
    check("hi_to_period",    int'(bus.period),  0);
    check("hi_to_valid_cnt", valid_cnt - vbase, 1);
    drive(1'b0, 10);
    check("hi_to_fall_valid", valid_cnt - vbase, 2);
    check("hi_to_fall_duty",  int'(bus.duty),    0);
    check("hi_to_fall_keep",  int'(bus.timeout), 1);
    drive(1'b1, 10);
    check("hi_to_rise_clear", int'(bus.timeout), 0);
    check("hi_to_rise_novalid", valid_cnt - vbase, 2);

    // Rising edge on the same cycle as the timeout limit: edge wins.
    apply_reset(0);
    drive(1'b0, 5);
    vbase = valid_cnt;
    tbase = to_cnt;
    drive(1'b1, 10);
    drive(1'b0, 502);
    drive(1'b1, 10);
    drive(1'b0, 10);
    check("edge512_valid_cnt", valid_cnt - vbase, 1);
    check("edge512_period",    cap_period, 511);
    check("edge512_duty",      cap_duty,   10);
    check("edge512_no_timeout", to_cnt - tbase, 0);

    // Rising edge just past the limit: timeout first, the edge only clears it.
    apply_reset(0);
    drive(1'b0, 5);
    vbase = valid_cnt;
    drive(1'b1, 10);
    drive(1'b0, 510);
    check("edge520_timeout", int'(bus.timeout), 1);
    drive(1'b1, 10);
    drive(1'b0, 10);
    check("edge520_valid_cnt", valid_cnt - vbase, 1);
    check("edge520_period",    cap_period, 0);
    check("edge520_duty",      cap_duty,   0);
    check("edge520_cleared",   int'(bus.timeout), 0);

    // Reset mid-measurement discards everything; valid needs two edges again.
    apply_reset(0);
    drive(1'b0, 5);
    drive(1'b1, 10);
    drive(1'b0, 20);
    drive(1'b1, 5);
    drive(1'b0, 5);
    check("pre_rst_duty",   int'(bus.duty),   10);
    check("pre_rst_period", int'(bus.period), 30);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_duty",    int'(bus.duty),    0);
    check("mid_rst_period",  int'(bus.period),  0);
    check("mid_rst_valid",   int'(bus.valid),   0);
    check("mid_rst_timeout", int'(bus.timeout), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vbase = valid_cnt;
    drive(1'b0, 5);
    drive(1'b1, 10);
    drive(1'b0, 20);
    check("post_rst_first_edge", valid_cnt - vbase, 0);
    drive(1'b1, 5);
    drive(1'b0, 10);
    check("post_rst_second_edge", valid_cnt - vbase, 1);
    check("post_rst_period", cap_period, 30);
    check("post_rst_duty",   cap_duty,   10);

`ifdef PWM_CAP_GLITCH_FILTER_EN
    // Two-clock glitch in the low phase is ignored.
    apply_reset(0);
    drive(1'b0, 5);
    drive(1'b1, 20);
    drive(1'b0, 80);
    vbase = valid_cnt;
    drive(1'b1, 20);
    drive(1'b0, 30);
    drive(1'b1, 2);
    drive(1'b0, 48);
    drive(1'b1, 20);
    drive(1'b0, 10);
    check("glitch2_valid_cnt", valid_cnt - vbase, 2);
    check("glitch2_period",    cap_period, 100);
    check("glitch2_duty",      cap_duty,   20);
    // Three-clock pulse is a real edge.
    vbase = valid_cnt;
    drive(1'b0, 20);
    drive(1'b1, 3);
    drive(1'b0, 47);
    drive(1'b1, 20);
    drive(1'b0, 10);
    check("glitch3_valid_cnt", valid_cnt - vbase, 2);
    check("glitch3_period",    cap_period, 50);
    check("glitch3_duty",      cap_duty,   3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have parameter R, default 8, which sets the duty resolution in bits (full scale 2^R).
REQ-002 Port clk SHALL be an input of width 1 and serve as the single system clock; all state SHALL be on its rising edge.
REQ-003 Port rst SHALL be an input of width 1: asynchronous, active-high reset.
REQ-004 Port pwm_in SHALL be an input of width 1 carrying the asynchronous PWM waveform under measurement.
REQ-005 Port dvsr SHALL be an input of width 32 giving the tick prescale; one tick SHALL occur every dvsr+1 clocks.
REQ-006 Port duty SHALL be an output of width R+1 giving the measured high time in ticks, in the range 0..2^R.
REQ-007 Port period SHALL be an output of width R+2 giving the measured period in ticks.
REQ-008 Port valid SHALL be an output of width 1 that pulses for one clock when duty/period update.
REQ-009 Port timeout SHALL be an output of width 1 that is high while no rising edge has arrived within the timeout window.

Function
REQ-010 pwm_in SHALL pass through a 2-FF synchronizer; the result, optionally filtered per REQ-027, is the sampled signal "s".
REQ-011 Rising and falling edges SHALL be detected on s; all later references to edges mean edges of s.
REQ-012 The prescaler SHALL count 0..dvsr and emit a tick when it equals dvsr, then wrap to 0; dvsr=0 SHALL give a tick every clock.
REQ-013 The prescaler SHALL be cleared to 0 in the cycle of each rising edge.
REQ-014 period_cnt (R+2 bits) SHALL increment on each tick; high_cnt (R+2 bits) SHALL increment on each tick while s=1; both SHALL be cleared on a rising edge.
REQ-015 The FSM SHALL have states WAIT (no reference edge) and RUN, and SHALL enter WAIT out of reset.
REQ-016 In WAIT, a rising edge SHALL clear the counters and move the FSM to RUN without asserting valid.
REQ-017 In RUN, a rising edge SHALL latch period<=period_cnt and duty<=min(high_cnt,2^R), pulse valid one clock later, and clear the counters.
REQ-018 Timeout SHALL be detected when period_cnt reaches 2^(R+1) with no rising edge, in either state.
REQ-019 On timeout the block SHALL set duty to 2^R if s=1 or to 0 if s=0, set period to 0, set timeout=1, pulse valid once, and enter WAIT.
REQ-020 While timed out, the counters SHALL hold and valid SHALL NOT re-pulse; a level change without a rising edge SHALL update duty (2^R/0) and pulse valid.
REQ-021 timeout SHALL clear on the next rising edge.
REQ-022 A rising edge and a timeout in the same cycle SHALL resolve with the rising edge winning.
REQ-023 For a generator toggling on the same tick grid, the measured duty SHALL be exact (a high time of D*(dvsr+1) clocks reads as D).
REQ-024 A change of dvsr SHALL take effect at the next prescaler wrap; the measurement in progress when dvsr changes is undefined.

Reset
REQ-025 While rst is asserted: duty=0, period=0, valid=0, timeout=0, the FSM in WAIT, all counters 0, and the synchronizer/filter flops at 0.
REQ-026 Reset asserted mid-measurement SHALL discard the partial measurement; after release, no valid SHALL occur before the second rising edge.

Configuration
REQ-027 With PWM_CAP_GLITCH_FILTER_EN defined, s SHALL change only after the synchronized input holds a new value for 3 consecutive clocks; pulses shorter than 3 clocks SHALL be ignored, and latency SHALL rise by 2 clocks.
REQ-028 With PWM_CAP_GLITCH_FILTER_EN undefined, s SHALL equal the synchronizer output and no filter logic SHALL exist.

Verification
REQ-029 R=8, dvsr=4, input high 320 clocks / low 960 clocks repeating -> from the 2nd rising edge on, each edge gives valid with duty=64 and period=256.
REQ-030 R=8, dvsr=0, input held low after one rising edge -> 512 clocks later timeout=1 with duty=0, period=0, and a single valid pulse.
REQ-031 R=8, dvsr=0, input held high -> timeout=1 with duty=256; a subsequent fall then rise clears timeout with no valid on that rise.
REQ-032 Rising edge injected exactly at tick 512 -> normal latch with period=511 or less and timeout stays 0.
REQ-033 With the macro defined, a 2-clock high glitch during a low phase -> no edge and duty unchanged; with a 3-clock glitch -> the edge is detected.
REQ-034 rst pulsed mid-period -> all outputs 0 and state WAIT; first valid after release only on the second rising edge.
